// File: rtl/gate_sensor_gen.sv
// Two-sensor parking-gate stimulus generator: drives the 4-phase Gray crossing sequence on ab_o.
// Build option: define GEN_ABORT_EN to compile in the abort/retrace (vehicle backs out) path.
module gate_sensor_gen #(
  parameter int unsigned DW_W  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_dir_i,
  input  logic [DW_W-1:0]  dwell_i,
  input  logic             abort_i,
  output logic [1:0]       ab_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] pass_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StP1,
    StP2,
    StP3
`ifdef GEN_ABORT_EN
    , StRetrace
`endif
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [DW_W-1:0]  n_q, n_d;
  logic [DW_W-1:0]  cnt_q, cnt_d;
  logic [1:0]       ab_q, ab_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic             phase_end;

`ifndef GEN_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort_i;
`endif

  // Entry sequence is the exit sequence with the two sensor bits swapped.
  function automatic logic [1:0] phase_code(input logic dir, input logic [1:0] idx);
    logic [1:0] c;
    case (idx)
      2'd1:    c = 2'b01;
      2'd2:    c = 2'b11;
      2'd3:    c = 2'b10;
      default: c = 2'b00;
    endcase
    return dir ? {c[0], c[1]} : c;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      n_q        <= DW_W'(1);
      cnt_q      <= DW_W'(1);
      ab_q       <= 2'b00;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      ab_q       <= ab_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign phase_end = (cnt_q == n_q);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    ab_d       = ab_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StP1;
          dir_d   = req_dir_i;
          n_d     = (dwell_i == '0) ? DW_W'(1) : dwell_i;
          cnt_d   = DW_W'(1);
          ab_d    = phase_code(req_dir_i, 2'd1);
        end
      end
      StP1, StP2, StP3: begin
        if (phase_end) begin
          cnt_d = DW_W'(1);
          case (state_q)
            StP1: begin
              state_d = StP2;
              ab_d    = phase_code(dir_q, 2'd2);
            end
            StP2: begin
              state_d = StP3;
              ab_d    = phase_code(dir_q, 2'd3);
            end
            default: begin
              state_d    = StIdle;
              ab_d       = 2'b00;
              done_d     = 1'b1;
              pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
          endcase
        end else begin
          cnt_d = cnt_q + DW_W'(1);
        end
`ifdef GEN_ABORT_EN
        // Abort overrides any phase advance made above, including completion out of P3.
        if (abort_i) begin
          cnt_d      = DW_W'(1);
          done_d     = 1'b0;
          pass_cnt_d = pass_cnt_q;
          if (state_q == StP1) begin
            state_d   = StIdle;
            ab_d      = 2'b00;
            aborted_d = 1'b1;
          end else begin
            state_d = StRetrace;
            ab_d    = phase_code(dir_q, (state_q == StP3) ? 2'd2 : 2'd1);
          end
        end
`endif
      end
`ifdef GEN_ABORT_EN
      StRetrace: begin
        if (phase_end) begin
          cnt_d = DW_W'(1);
          // 11 is only ever the retraced P2 code; anything else is the retraced P1 code.
          if (ab_q == 2'b11) begin
            ab_d = phase_code(dir_q, 2'd1);
          end else begin
            state_d   = StIdle;
            ab_d      = 2'b00;
            aborted_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DW_W'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    ab_o        = ab_q;
    done_o      = done_q;
    aborted_o   = aborted_q;
    pass_cnt_o  = pass_cnt_q;
  end

endmodule
